load_store_unit: RTL and testbench

- Sits between the single-cycle core's memory stage and the word-addressed data memory.
- Converts byte addresses from the core into word indices for the data memory.
- Implements all RV32I load and store widths: LB/LH/LW/LBU/LHU and SB/SH/SW.
- The data memory only handles whole 32-bit words, so sub-word stores use a read-modify-write sequence.
- Detects misaligned and illegal accesses without touching memory.
- Uses a start/done handshake so the core can stall while an access is in flight.

---
 rtl/load_store_unit_if.sv | 30 +++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// The LSU uses the slave view; the core/memory environment uses the master view.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              start;
    logic              is_store;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic [31:0]       rdata;
    logic              misaligned;
    logic              illegal;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic [31:0]       mem_rd;

    modport master (
        output start, is_store, funct3, addr, wdata, mem_rd,
        input  busy, done, rdata, misaligned, illegal, mem_we, mem_addr, mem_wd
    );

    modport slave (
        input  start, is_store, funct3, addr, wdata, mem_rd,
        output busy, done, rdata, misaligned, illegal, mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit for a word-only data memory: byte/half/word loads,
// read-modify-write sub-word stores, fault detection, start/done handshake.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_CAP, WR} state_e;

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              misaligned_q, misaligned_d;
    logic              illegal_q, illegal_d;
    logic              mem_we_q, mem_we_d;

    logic              req_illegal, req_misaligned;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_fmt;
    logic [31:0]       merged;

    always_comb begin
        if (bus.is_store)
            req_illegal = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
        else
            req_illegal = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11);
        req_misaligned = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                         ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    end

    always_comb begin
        ld_byte = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
        ld_half = bus.mem_rd[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'h000000, ld_byte};
            3'b101:  ld_fmt = {16'h0000, ld_half};
            default: ld_fmt = bus.mem_rd;
        endcase
    end

    always_comb begin
        merged = bus.mem_rd;
        if (funct3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (funct3_q[1:0] == 2'b01)
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        merge_d      = merge_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        illegal_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_store_d = bus.is_store;
                    funct3_d   = bus.funct3;
                    addr_d     = bus.addr;
                    wdata_d    = bus.wdata;
                    // Illegal takes priority; faults complete without leaving IDLE.
                    if (req_illegal) begin
                        illegal_d = 1'b1;
                        done_d    = 1'b1;
                    end else if (req_misaligned) begin
                        misaligned_d = 1'b1;
                        done_d       = 1'b1;
                    end else if (bus.is_store && (bus.funct3[1:0] == 2'b10)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: state_d = RD_CAP;
            RD_CAP: begin
                if (is_store_q) begin
                    merge_d = merged;
                    state_d = WR;
                end else begin
                    rdata_d = ld_fmt;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered from the next state so a reset on the entry edge also kills the write.
        mem_we_d = (state_d == WR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            merge_q      <= '0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            merge_q      <= merge_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
            mem_we_q     <= mem_we_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.rdata      = rdata_q;
    assign bus.misaligned = misaligned_q;
    assign bus.illegal    = illegal_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = {2'b00, addr_q[ADDR_W-1:2]};
    assign bus.mem_wd     = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small registered-read word memory.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_idx] <= pre_val;
        else if (bus.mem_we)
            mem[bus.mem_addr[5:0]] <= bus.mem_wd;
        else
            bus.mem_rd <= mem[bus.mem_addr[5:0]];
    end

    int unsigned we_total   = 0;
    int unsigned done_total = 0;
    logic [31:0] we_addr_last = '0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            we_total     <= we_total + 1;
            we_addr_last <= bus.mem_addr;
        end
        if (bus.done)
            done_total <= done_total + 1;
    end

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic op(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int unsigned exp_lat, input logic [31:0] exp_rd,
                      input logic exp_mis, input logic exp_ill, input int unsigned exp_we);
        int unsigned we0, dn0, lat;
        we0 = we_total;
        dn0 = done_total;
        bus.start = 1'b1; bus.is_store = st; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".rdata"}, bus.rdata, exp_rd);
        chk({tag, ".mis"}, {31'd0, bus.misaligned}, {31'd0, exp_mis});
        chk({tag, ".ill"}, {31'd0, bus.illegal}, {31'd0, exp_ill});
        @(posedge clk); #1;
        chk({tag, ".done_drop"}, {31'd0, bus.done}, 32'd0);
        chk({tag, ".done_cnt"}, done_total - dn0, 32'd1);
        chk({tag, ".we_cnt"}, we_total - we0, exp_we);
        if (exp_we != 0)
            chk({tag, ".we_addr"}, we_addr_last, {2'b00, a[31:2]});
    endtask

    initial begin
        bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = '0; bus.addr = '0; bus.wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        preload(6'd5, 32'h8765_4321);
        preload(6'd9, 32'h1357_9BDF);
        rst = 1'b0;
        chk("rst.busy", {31'd0, bus.busy}, 32'd0);
        chk("rst.done", {31'd0, bus.done}, 32'd0);
        chk("rst.rdata", bus.rdata, 32'd0);
        chk("rst.we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst.flags", {30'd0, bus.misaligned, bus.illegal}, 32'd0);

        // Loads from word 5
        op("lb15",  1'b0, 3'b000, 32'h15, 32'h0, 3, 32'h0000_0043, 1'b0, 1'b0, 0);
        op("lb17",  1'b0, 3'b000, 32'h17, 32'h0, 3, 32'hFFFF_FF87, 1'b0, 1'b0, 0);
        op("lbu17", 1'b0, 3'b100, 32'h17, 32'h0, 3, 32'h0000_0087, 1'b0, 1'b0, 0);
        op("lh16",  1'b0, 3'b001, 32'h16, 32'h0, 3, 32'hFFFF_8765, 1'b0, 1'b0, 0);
        op("lhu16", 1'b0, 3'b101, 32'h16, 32'h0, 3, 32'h0000_8765, 1'b0, 1'b0, 0);

        // Word store then readback
        op("sw20", 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 2, 32'h0000_8765, 1'b0, 1'b0, 1);
        chk("sw20.mem", mem[8], 32'hDEAD_BEEF);
        op("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);

        // Sub-word read-modify-write stores
        op("sb21", 1'b1, 3'b000, 32'h21, 32'hFFFF_FFAA, 4, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
        chk("sb21.mem", mem[8], 32'hDEAD_AAEF);
        op("sh22", 1'b1, 3'b001, 32'h22, 32'h0000_1234, 4, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
        chk("sh22.mem", mem[8], 32'h1234_AAEF);

        // Faults: done in cycle 1, no memory write, rdata untouched
        op("lh21",   1'b0, 3'b001, 32'h21, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
        op("sw22",   1'b1, 3'b010, 32'h22, 32'h5555_5555, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
        op("ld011",  1'b0, 3'b011, 32'h20, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, 1'b1, 0);
        op("st100",  1'b1, 3'b100, 32'h20, 32'h6666_6666, 1, 32'hDEAD_BEEF, 1'b0, 1'b1, 0);
        op("st101m", 1'b1, 3'b101, 32'h21, 32'h7777_7777, 1, 32'hDEAD_BEEF, 1'b0, 1'b1, 0);
        chk("fault.mem", mem[8], 32'h1234_AAEF);

        // SB aborted by reset during RD_CAP
        begin
            int unsigned we0, dn0;
            we0 = we_total;
            dn0 = done_total;
            bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b000;
            bus.addr = 32'h20; bus.wdata = 32'h0000_0099;
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("abort.busy", {31'd0, bus.busy}, 32'd0);
            chk("abort.done", {31'd0, bus.done}, 32'd0);
            chk("abort.we", {31'd0, bus.mem_we}, 32'd0);
            chk("abort.rdata", bus.rdata, 32'd0);
            chk("abort.flags", {30'd0, bus.misaligned, bus.illegal}, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            chk("abort.we_cnt", we_total - we0, 32'd0);
            chk("abort.done_cnt", done_total - dn0, 32'd0);
            chk("abort.mem", mem[8], 32'h1234_AAEF);
        end
        op("lw20b", 1'b0, 3'b010, 32'h20, 32'h0, 3, 32'h1234_AAEF, 1'b0, 1'b0, 0);

        // Back-to-back with start held high
        begin
            int unsigned dn0;
            dn0 = done_total;
            bus.start = 1'b1; bus.is_store = 1'b0; bus.funct3 = 3'b010; bus.addr = 32'h20;
            @(posedge clk); #1;
            bus.addr = 32'h24;
            chk("b2b.c1.busy", {31'd0, bus.busy}, 32'd1);
            chk("b2b.c1.maddr", bus.mem_addr, 32'd8);
            @(posedge clk); #1;
            chk("b2b.c2.done", {31'd0, bus.done}, 32'd0);
            @(posedge clk); #1;
            chk("b2b.c3.done", {31'd0, bus.done}, 32'd1);
            chk("b2b.c3.busy", {31'd0, bus.busy}, 32'd0);
            chk("b2b.c3.rdata", bus.rdata, 32'h1234_AAEF);
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk("b2b.c4.busy", {31'd0, bus.busy}, 32'd1);
            chk("b2b.c4.done", {31'd0, bus.done}, 32'd0);
            chk("b2b.c4.maddr", bus.mem_addr, 32'd9);
            chk("b2b.c4.rdata", bus.rdata, 32'h1234_AAEF);
            @(posedge clk); #1;
            chk("b2b.c5.done", {31'd0, bus.done}, 32'd0);
            chk("b2b.c5.rdata", bus.rdata, 32'h1234_AAEF);
            @(posedge clk); #1;
            chk("b2b.c6.done", {31'd0, bus.done}, 32'd1);
            chk("b2b.c6.rdata", bus.rdata, 32'h1357_9BDF);
            repeat (3) @(posedge clk);
            #1;
            chk("b2b.done_cnt", done_total - dn0, 32'd2);
            chk("b2b.idle", {31'd0, bus.busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
